// File: rtl/clk_div_monitor_if.sv
// Interface for the clock-divider monitor.
// Carries the monitored clock in and every measurement/status output back out.
interface clk_div_monitor_if #(
  parameter int CNT_W = 32
);
  logic             clk_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic [CNT_W-1:0] n_est;
  logic             locked;
  logic             timeout_pulse;

  // Source side: drives the slow clock and observes the results.
  modport master (
    output clk_in,
    input  rise_pulse, fall_pulse, half_period, meas_valid,
    input  n_est, locked, timeout_pulse
  );

  // Monitor side: samples the slow clock and produces the results.
  modport slave (
    input  clk_in,
    output rise_pulse, fall_pulse, half_period, meas_valid,
    output n_est, locked, timeout_pulse
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Receive-side monitor for a divide-by-N clock.
// Synchronizes clk_in, detects its edges, measures the half-period in
// reference_clk cycles, locks once several measurements agree and flags a
// lost clock when no edge arrives for TIMEOUT cycles.
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 100000
) (
  input logic               reference_clk,
  input logic               reset,
  clk_div_monitor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  // One spare bit so the match counter can never wrap, even for LOCK_COUNT=1.
  localparam int MW = $clog2(LOCK_COUNT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W + 1)'(TOL);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MW-1:0]          match_cnt_q, match_cnt_d;
  state_t                 state_q, state_d;
  logic                   rise_pulse_q, rise_pulse_d;
  logic                   fall_pulse_q, fall_pulse_d;
  logic [CNT_W-1:0]       half_period_q, half_period_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [CNT_W-1:0]       n_est_q, n_est_d;
  logic                   locked_q, locked_d;
  logic                   timeout_pulse_q, timeout_pulse_d;

  logic                   sync_s;
  logic                   edge_det;
  logic [CNT_W:0]         meas;
  logic [CNT_W:0]         n_ext;
  logic [CNT_W:0]         diff;
  logic                   is_match;
  logic [MW-1:0]          mc_next;

  // Next-state logic: synchronizer, edge detect, counter and lock FSM.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.clk_in};
    sync_s   = sync_q[SYNC_STAGES-1];
    edge_det = sync_s ^ prev_q;
    prev_d   = sync_s;

    meas     = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    n_ext    = {1'b0, n_est_q};
    diff     = (meas >= n_ext) ? (meas - n_ext) : (n_ext - meas);
    is_match = (diff <= TOL_W);

    cnt_d           = edge_det ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
    state_d         = state_q;
    match_cnt_d     = match_cnt_q;
    mc_next         = match_cnt_q;
    n_est_d         = n_est_q;
    locked_d        = locked_q;
    half_period_d   = half_period_q;
    meas_valid_d    = 1'b0;
    timeout_pulse_d = 1'b0;
    rise_pulse_d    = edge_det & sync_s;
    fall_pulse_d    = edge_det & ~sync_s;

    case (state_q)
      IDLE: begin
        if (edge_det) state_d = ACQ;
      end
      ACQ: begin
        if (edge_det) begin
          half_period_d = meas[CNT_W-1:0];
          meas_valid_d  = 1'b1;
          if (match_cnt_q == '0 || !is_match) begin
            n_est_d = meas[CNT_W-1:0];
            mc_next = MW'(1);
          end else if (match_cnt_q < LOCK_N) begin
            mc_next = match_cnt_q + MW'(1);
          end
          match_cnt_d = mc_next;
          if (mc_next >= LOCK_N) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d         = IDLE;
          timeout_pulse_d = 1'b1;
          locked_d        = 1'b0;
          match_cnt_d     = '0;
          n_est_d         = '0;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          half_period_d = meas[CNT_W-1:0];
          meas_valid_d  = 1'b1;
          if (!is_match) begin
            locked_d    = 1'b0;
            n_est_d     = meas[CNT_W-1:0];
            match_cnt_d = MW'(1);
            state_d     = ACQ;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d         = IDLE;
          timeout_pulse_d = 1'b1;
          locked_d        = 1'b0;
          match_cnt_d     = '0;
          n_est_d         = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge reference_clk or posedge reset) begin
    if (reset) begin
      sync_q          <= '0;
      prev_q          <= 1'b0;
      cnt_q           <= '0;
      match_cnt_q     <= '0;
      state_q         <= IDLE;
      rise_pulse_q    <= 1'b0;
      fall_pulse_q    <= 1'b0;
      half_period_q   <= '0;
      meas_valid_q    <= 1'b0;
      n_est_q         <= '0;
      locked_q        <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      prev_q          <= prev_d;
      cnt_q           <= cnt_d;
      match_cnt_q     <= match_cnt_d;
      state_q         <= state_d;
      rise_pulse_q    <= rise_pulse_d;
      fall_pulse_q    <= fall_pulse_d;
      half_period_q   <= half_period_d;
      meas_valid_q    <= meas_valid_d;
      n_est_q         <= n_est_d;
      locked_q        <= locked_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign bus.rise_pulse    = rise_pulse_q;
  assign bus.fall_pulse    = fall_pulse_q;
  assign bus.half_period   = half_period_q;
  assign bus.meas_valid    = meas_valid_q;
  assign bus.n_est         = n_est_q;
  assign bus.locked        = locked_q;
  assign bus.timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: drives clk_in with known half-periods, predicts
// each published measurement and each timeout, and checks them as they appear.
module tb_clk_div_monitor;

  localparam int CNT_W      = 32;
  localparam int TIMEOUT    = 50;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;

  logic reference_clk = 1'b0;
  logic reset;

  clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

  clk_div_monitor #(
    .SYNC_STAGES (2),
    .CNT_W       (CNT_W),
    .TOL         (TOL),
    .LOCK_COUNT  (LOCK_COUNT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .reference_clk (reference_clk),
    .reset         (reset),
    .bus           (bus)
  );

  // Free-running reference clock.
  always #5 reference_clk = ~reference_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [CNT_W-1:0] meas;
    logic [CNT_W-1:0] n;
    logic             lk;
  } exp_t;

  exp_t             meas_q[$];
  logic [CNT_W-1:0] to_q[$];
  logic             pol_q[$];

  int m_state;
  int m_n;
  int m_mc;
  int m_locked;
  int m_last;
  int since_toggle;
  int cyc = 0;
  int last_pulse_cyc = 0;
  int timeout_seen = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Transaction-level prediction of one detected edge after a gap of 'gap' cycles.
  task automatic modelEdge(input int gap);
    int   d;
    logic match;
    exp_t e;
    if (m_state == 0) begin
      m_state = 1;
    end else begin
      m_last = gap;
      d      = (gap > m_n) ? gap - m_n : m_n - gap;
      match  = (d <= TOL);
      if (m_state == 1) begin
        if (m_mc == 0 || !match) begin
          m_n  = gap;
          m_mc = 1;
        end else if (m_mc < LOCK_COUNT) begin
          m_mc++;
        end
        if (m_mc >= LOCK_COUNT) begin
          m_state  = 2;
          m_locked = 1;
        end
      end else if (!match) begin
        m_locked = 0;
        m_n      = gap;
        m_mc     = 1;
        m_state  = 1;
      end
      e.meas = CNT_W'(gap);
      e.n    = CNT_W'(m_n);
      e.lk   = m_locked[0];
      meas_q.push_back(e);
    end
  endtask

  task automatic modelReset();
    m_state  = 0;
    m_n      = 0;
    m_mc     = 0;
    m_locked = 0;
    m_last   = 0;
  endtask

  // Toggle clk_in 'gap' cycles after the previous toggle and log predictions.
  task automatic applyStimulus(input int gap);
    if (m_state != 0 && gap > TIMEOUT) begin
      to_q.push_back(CNT_W'(m_last));
      m_state  = 0;
      m_n      = 0;
      m_mc     = 0;
      m_locked = 0;
    end
    repeat (gap - since_toggle) @(posedge reference_clk);
    #1 bus.clk_in = ~bus.clk_in;
    since_toggle = 0;
    pol_q.push_back(bus.clk_in);
    modelEdge(gap);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge reference_clk);
    since_toggle += n;
  endtask

  task automatic checkState(input string tag, input logic lk, input logic [CNT_W-1:0] n);
    @(negedge reference_clk);
    checkOutput({tag, "_locked"}, bus.locked, lk);
    checkOutput({tag, "_n_est"}, bus.n_est, n);
  endtask

  // Cycle count for timing the timeout.
  always @(posedge reference_clk) cyc = cyc + 1;

  // Scoreboard: pop predictions whenever the DUT produces an output event.
  always @(negedge reference_clk) begin : monitor
    exp_t             e;
    logic             p;
    logic [CNT_W-1:0] th;
    if (!reset) begin
      if (bus.rise_pulse || bus.fall_pulse) begin
        checkOutput("pulse_both", bus.rise_pulse & bus.fall_pulse, 0);
        if (pol_q.size() == 0) begin
          checkOutput("pulse_unexpected", 1, 0);
        end else begin
          p = pol_q.pop_front();
          checkOutput("pulse_polarity", bus.rise_pulse, p);
        end
        last_pulse_cyc = cyc;
      end
      if (bus.meas_valid) begin
        if (meas_q.size() == 0) begin
          checkOutput("meas_unexpected", bus.half_period, 0);
        end else begin
          e = meas_q.pop_front();
          checkOutput("half_period", bus.half_period, e.meas);
          checkOutput("meas_n_est", bus.n_est, e.n);
          checkOutput("meas_locked", bus.locked, e.lk);
          checkOutput("meas_no_timeout", bus.timeout_pulse, 0);
        end
      end
      if (bus.timeout_pulse) begin
        timeout_seen++;
        if (to_q.size() == 0) begin
          checkOutput("timeout_unexpected", 1, 0);
        end else begin
          th = to_q.pop_front();
          checkOutput("timeout_delay", cyc - last_pulse_cyc, TIMEOUT);
          checkOutput("timeout_locked", bus.locked, 0);
          checkOutput("timeout_n_est", bus.n_est, 0);
          checkOutput("timeout_half_hold", bus.half_period, th);
        end
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.clk_in   = 1'b0;
    since_toggle = 0;
    modelReset();
    repeat (3) @(posedge reference_clk);
    @(negedge reference_clk);
    checkOutput("rst_rise", bus.rise_pulse, 0);
    checkOutput("rst_fall", bus.fall_pulse, 0);
    checkOutput("rst_half", bus.half_period, 0);
    checkOutput("rst_valid", bus.meas_valid, 0);
    checkOutput("rst_n_est", bus.n_est, 0);
    checkOutput("rst_locked", bus.locked, 0);
    checkOutput("rst_timeout", bus.timeout_pulse, 0);
    reset = 1'b0;

    $display("[TB] lock on N=5");
    repeat (4) applyStimulus(5);
    waitCycles(4);
    checkState("pre_lock", 1'b0, 5);
    applyStimulus(5);
    waitCycles(4);
    checkState("lock5", 1'b1, 5);
    repeat (2) applyStimulus(5);

    $display("[TB] tolerance");
    applyStimulus(5);
    applyStimulus(6);
    applyStimulus(4);
    applyStimulus(5);
    waitCycles(4);
    checkState("jitter", 1'b1, 5);
    applyStimulus(8);
    waitCycles(4);
    checkState("jump8", 1'b0, 8);
    repeat (3) applyStimulus(8);
    waitCycles(4);
    checkState("lock8", 1'b1, 8);

    $display("[TB] frequency change");
    applyStimulus(5);
    repeat (3) applyStimulus(5);
    applyStimulus(12);
    waitCycles(4);
    checkState("switch12", 1'b0, 12);
    repeat (2) applyStimulus(12);
    waitCycles(4);
    checkState("acq12", 1'b0, 12);
    applyStimulus(12);
    waitCycles(4);
    checkState("lock12", 1'b1, 12);
    repeat (4) applyStimulus(5);

    $display("[TB] loss of clock");
    applyStimulus(TIMEOUT + 100);
    waitCycles(4);
    checkState("restart", 1'b0, 0);
    repeat (4) applyStimulus(5);
    waitCycles(4);
    checkState("relock", 1'b1, 5);

    $display("[TB] edge/timeout race");
    applyStimulus(TIMEOUT);
    waitCycles(4);
    checkState("race", 1'b0, TIMEOUT);
    applyStimulus(TIMEOUT + 1);
    repeat (4) applyStimulus(5);

    $display("[TB] async reset mid-lock");
    waitCycles(10);
    @(negedge reference_clk);
    #2;
    reset      = 1'b1;
    bus.clk_in = 1'b0;
    #1;
    checkOutput("arst_rise", bus.rise_pulse, 0);
    checkOutput("arst_fall", bus.fall_pulse, 0);
    checkOutput("arst_half", bus.half_period, 0);
    checkOutput("arst_valid", bus.meas_valid, 0);
    checkOutput("arst_n_est", bus.n_est, 0);
    checkOutput("arst_locked", bus.locked, 0);
    checkOutput("arst_timeout", bus.timeout_pulse, 0);
    repeat (3) @(posedge reference_clk);
    @(negedge reference_clk);
    reset = 1'b0;
    meas_q.delete();
    pol_q.delete();
    to_q.delete();
    modelReset();
    since_toggle = 0;
    repeat (4) applyStimulus(5);
    waitCycles(4);
    checkState("arst_acq", 1'b0, 5);
    applyStimulus(5);
    waitCycles(4);
    checkState("arst_lock", 1'b1, 5);

    waitCycles(10);
    checkOutput("meas_q_left", meas_q.size(), 0);
    checkOutput("pol_q_left", pol_q.size(), 0);
    checkOutput("to_q_left", to_q.size(), 0);
    checkOutput("timeout_count", timeout_seen, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
